// File: rtl/truth_table_scanner.sv
//------------------------------------------------------------------------------
// Module      : truth_table_scanner
// Description : Sweeps every input vector through a same-clock combinational
//               block, samples its output after a settle time, and compares
//               the measured truth table against an expected code.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module truth_table_scanner #(
    parameter int                        N_INPUTS      = 3,
    parameter int                        SETTLE_CYCLES = 4,
    parameter logic [(1<<N_INPUTS)-1:0]  EXPECTED      = 8'hE8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic [N_INPUTS-1:0]          dut_in,
    input  logic                         dut_out,
    output logic                         busy,
    output logic                         done,
    output logic [(1<<N_INPUTS)-1:0]     truth_table,
    output logic                         match,
    output logic [(1<<N_INPUTS)-1:0]     mismatch_mask,
    output logic [7:0]                   pass_count,
    output logic [7:0]                   fail_count
);

    localparam int                   c_NVEC     = 1 << N_INPUTS;
    localparam logic [7:0]           c_LAST_CNT = 8'(SETTLE_CYCLES - 1);
    localparam logic [N_INPUTS-1:0]  c_LAST_IDX = '1;
    localparam logic [N_INPUTS-1:0]  c_IDX_ONE  = N_INPUTS'(1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_HOLD = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]              r_state;
    logic [1:0]              w_state_next;
    logic [N_INPUTS-1:0]     r_idx;
    logic [7:0]              r_cnt;
    logic [c_NVEC-1:0]       r_table;
    logic [c_NVEC-1:0]       w_table_next;
    logic                    r_match;
    logic [c_NVEC-1:0]       r_mask;
    logic [7:0]              r_pass;
    logic [7:0]              r_fail;
    logic                    w_sample;
    logic                    w_last;
    logic                    w_new_match;

    assign w_sample    = (r_state == c_HOLD) && (r_cnt == c_LAST_CNT);
    assign w_last      = w_sample && (r_idx == c_LAST_IDX);
    assign w_new_match = (w_table_next == EXPECTED);

    // Table as it will be after this edge's sample, so the compare in the
    // edge entering DONE already sees the final bit.
    always_comb begin
        w_table_next = r_table;
        if (w_sample) begin
            w_table_next[r_idx] = dut_out;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (start)  w_state_next = c_HOLD;
            c_HOLD:  if (w_last) w_state_next = c_DONE;
            c_DONE:  w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    always_comb begin
        busy   = (r_state != c_IDLE);
        done   = (r_state == c_DONE);
        dut_in = (r_state == c_HOLD) ? r_idx : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= '0;
            r_cnt   <= '0;
            r_table <= '0;
            r_match <= 1'b0;
            r_mask  <= '0;
            r_pass  <= '0;
            r_fail  <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_idx   <= '0;
                        r_cnt   <= '0;
                        r_table <= '0;
                        r_match <= 1'b0;
                        r_mask  <= '0;
                    end
                end
                c_HOLD: begin
                    if (w_sample) begin
                        r_table <= w_table_next;
                        r_cnt   <= '0;
                        if (w_last) begin
                            r_match <= w_new_match;
                            r_mask  <= w_table_next ^ EXPECTED;
                            if (w_new_match) begin
                                if (r_pass != 8'hFF) r_pass <= r_pass + 8'd1;
                            end else begin
                                if (r_fail != 8'hFF) r_fail <= r_fail + 8'd1;
                            end
                        end else begin
                            r_idx <= r_idx + c_IDX_ONE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                c_DONE: begin
                    r_idx <= '0;
                    r_cnt <= '0;
                end
                default: begin
                    r_idx <= '0;
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign truth_table   = r_table;
    assign match         = r_match;
    assign mismatch_mask = r_mask;
    assign pass_count    = r_pass;
    assign fail_count    = r_fail;

endmodule

`default_nettype wire

// File: doc/truth_table_scanner.md
Name: truth_table_scanner

Overview:
- Sequential stimulus/response stage wrapped around a combinational 3-input logic block (e.g. the 0xE8 majority gate network).
- Sweeps all 2^N_INPUTS input vectors into the block, holds each for a programmable settle time, and samples the block output.
- Assembles the measured truth table and compares it against an expected hex code.
- Keeps saturating pass/fail tallies for regression runs.

Parameters:
N_INPUTS, 3, number of block inputs; vectors swept = 2^N_INPUTS.
SETTLE_CYCLES, 4, cycles each vector is held before sampling; legal range 1..255.
EXPECTED, 8'hE8, expected truth table (width 2^N_INPUTS); bit i = output for input vector i.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  one-cycle request to begin a sweep; honoured only in IDLE.
dut_in  output  N_INPUTS  vector driven to the block; bit0->in1, bit1->in2, bit2->in3.
dut_out  input  1  block output (out).
busy  output  1  high from the cycle after an accepted start until DONE is left.
done  output  1  one-cycle pulse when the sweep result is valid.
truth_table  output  2^N_INPUTS  measured table; held until the next accepted start.
match  output  1  truth_table == EXPECTED; valid with done, held afterwards.
mismatch_mask  output  2^N_INPUTS  truth_table XOR EXPECTED; held with truth_table.
pass_count  output  8  sweeps with match=1; saturates at 255.
fail_count  output  8  sweeps with match=0; saturates at 255.

Behaviour:
- Reset (async assert, sync deassert by the environment): all outputs 0; state IDLE; vector index 0; settle counter 0.
- States: IDLE, HOLD, DONE.
- IDLE:
  - start=1 -> next edge: dut_in=0, idx=0, cnt=0, truth_table=0, match=0, mismatch_mask=0, busy=1; go to HOLD.
  - start=0 -> remain in IDLE; dut_in=0.
- HOLD:
  - cnt increments each cycle.
  - On the edge where cnt==SETTLE_CYCLES-1: truth_table[idx] <= dut_out (dut_out is sampled without a synchroniser; the block is same-clock combinational).
  - If idx==2^N_INPUTS-1: go to DONE. Otherwise idx<=idx+1, dut_in<=idx+1, cnt<=0.
  - Each vector is therefore driven for exactly SETTLE_CYCLES cycles.
- DONE (one cycle):
  - done=1; busy stays 1.
  - match and mismatch_mask are computed from the completed table.
  - Increment pass_count or fail_count, saturating at 255.
  - dut_in<=0; next state IDLE, where busy=0.
- Latency: done asserts 1 + 2^N_INPUTS*SETTLE_CYCLES cycles after the start edge. With defaults that is 33.
- start while busy (HOLD or DONE) is ignored; no queuing.
- start in the first IDLE cycle after DONE is accepted, giving back-to-back sweeps.
- The final table bit is written in the same edge that enters DONE. The compare uses the next-state table value, so match is never stale.
- SETTLE_CYCLES=1: the vector changes every cycle, and the sample for vector i occurs on the edge that drives vector i+1.
- Reset mid-sweep: immediate abort. Partial table is discarded (cleared to 0), counters cleared, done is not pulsed.
- Counters change only in DONE. They are not cleared by start, only by rst.

Test Plan:
- Majority model on dut_out, defaults, start pulse -> dut_in steps 0..7, 4 cycles each. done at cycle 33; truth_table=0xE8, match=1, mismatch_mask=0x00, pass_count=1.
- Stuck-at-0 dut_out -> truth_table=0x00, match=0, mismatch_mask=0xE8, fail_count=1, pass_count unchanged.
- Model with vector 5 output inverted (0xC8) -> mismatch_mask=0x20, match=0. Pulse start again during HOLD -> ignored; exactly one done.
- Assert rst when idx=3 -> all outputs 0 immediately (asynchronous). No done. A new start yields a fresh full sweep and 0xE8.
- SETTLE_CYCLES=1, start held high continuously for 300 sweeps -> done every 10 cycles (8 HOLD + DONE + IDLE). pass_count saturates at 255 with no wrap.
- SETTLE_CYCLES=2, model with a one-cycle output delay register -> table still 0xE8. With SETTLE_CYCLES=1 -> table equals 0xE8 shifted by one vector (0xD0); verifies sample timing.
